// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction-fetch slice.
//   XLEN        - default PC/address width
//   ILEN        - default instruction width
//   INSTR_BYTES - sequential PC increment
//   seq_state_e - fetch sequencer state encoding
package fetch_pkg;

  localparam int unsigned XLEN        = 64;
  localparam int unsigned ILEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    SeqIdle,
    SeqReq,
    SeqWait,
    SeqDrop
  } seq_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small fetch queue of {pc, instr} entries.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   push, wdata  - enqueue an entry (ignored when full unless popping same cycle)
//   pop          - dequeue the head entry (ignored when empty)
//   flush        - clear the queue; overrides push and pop
//   rdata        - head entry, zero when empty
//   count        - number of valid entries
module fetch_fifo #(
  parameter int unsigned Width = 96,
  parameter int unsigned Depth = 2,
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [Width-1:0] rdata,
  output logic [CntW-1:0]  count
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop, is_empty;

  assign is_empty = (count_q == '0);
  assign do_pop   = pop && !is_empty;
  // A push into a full queue is only safe when the head leaves on the same edge.
  assign do_push  = push && ((count_q != CntW'(Depth)) || do_pop);

  // Depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AddrW'(1);
      if (do_pop)  rptr_q <= rptr_q + AddrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q] <= wdata;
  end

  assign rdata = is_empty ? '0 : mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer with a single outstanding request.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   pc_cur               - current PC from the PC register
//   pc_next, pc_write    - PC register load value / enable
//   imem_req, imem_addr  - instruction-memory request
//   imem_gnt             - request accepted this cycle
//   imem_rvalid/rdata    - instruction-memory response
//   redirect/redirect_pc - taken branch: flush and refetch from target
//   if_valid/pc/instr    - head of the fetch queue towards decode
//   if_ready             - decode consumes the head
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN     = fetch_pkg::XLEN,
  parameter int unsigned ILEN     = fetch_pkg::ILEN,
  parameter int unsigned FQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_write,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [ILEN-1:0] if_instr,
  input  logic            if_ready
);

  localparam int unsigned CntW = $clog2(FQ_DEPTH) + 1;

  seq_state_e           state_q, state_d;
  logic [XLEN-1:0]      req_pc_q, req_pc_d;
  logic [CntW-1:0]      fq_count;
  logic [XLEN+ILEN-1:0] fq_head;
  logic                 fq_push, fq_pop, fq_flush, can_req;

  // Only one request is ever in flight, so one free slot is enough credit.
  assign can_req = (fq_count < CntW'(FQ_DEPTH));

  always_comb begin
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    pc_write  = 1'b0;
    pc_next   = '0;
    imem_req  = 1'b0;
    imem_addr = '0;
    fq_push   = 1'b0;
    fq_flush  = 1'b0;
    case (state_q)
      SeqIdle: state_d = SeqReq;
      SeqReq: begin
        imem_req = can_req;
        if (can_req) imem_addr = pc_cur;
        if (redirect) begin
          pc_write = 1'b1;
          pc_next  = redirect_pc;
          fq_flush = 1'b1;
        end else if (can_req && imem_gnt) begin
          pc_write = 1'b1;
          pc_next  = pc_cur + XLEN'(INSTR_BYTES);
          req_pc_d = pc_cur;
          state_d  = SeqWait;
        end
      end
      SeqWait: begin
        if (redirect) begin
          pc_write = 1'b1;
          pc_next  = redirect_pc;
          fq_flush = 1'b1;
          state_d  = imem_rvalid ? SeqReq : SeqDrop;
        end else if (imem_rvalid) begin
          fq_push = 1'b1;
          state_d = SeqReq;
        end
      end
      SeqDrop: begin
        if (redirect) begin
          pc_write = 1'b1;
          pc_next  = redirect_pc;
          fq_flush = 1'b1;
        end
        // The stale response ends the drop even if another redirect lands with it.
        if (imem_rvalid) state_d = SeqReq;
      end
      default: state_d = SeqIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SeqIdle;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Flush takes precedence over a coincident pop inside the queue.
  assign fq_pop = if_valid && if_ready;

  fetch_fifo #(
    .Width(XLEN + ILEN),
    .Depth(FQ_DEPTH)
  ) u_fetch_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fq_push),
    .wdata({req_pc_q, imem_rdata}),
    .pop  (fq_pop),
    .flush(fq_flush),
    .rdata(fq_head),
    .count(fq_count)
  );

  assign if_valid = (fq_count != '0);
  assign if_pc    = fq_head[XLEN+ILEN-1:ILEN];
  assign if_instr = fq_head[ILEN-1:0];

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter XLEN, default 64: PC/address width.
REQ-002 Parameter ILEN, default 32: instruction width.
REQ-003 Parameter FQ_DEPTH, default 2: fetch-queue entries (power of two, >=2).
REQ-004 clk  in  1  system clock; all state updates on posedge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 pc_cur  in  XLEN  current PC from PC register.
REQ-007 pc_next  out  XLEN  value the PC register loads when pc_write=1.
REQ-008 pc_write  out  1  PC register write enable.
REQ-009 imem_req  out  1  instruction-memory request valid.
REQ-010 imem_addr  out  XLEN  request address.
REQ-011 imem_gnt  in  1  request accepted this cycle.
REQ-012 imem_rvalid  in  1  response data valid.
REQ-013 imem_rdata  in  ILEN  response instruction.
REQ-014 redirect  in  1  branch/jump taken; flush and refetch.
REQ-015 redirect_pc  in  XLEN  redirect target.
REQ-016 if_valid  out  1  fetched instruction available to decode.
REQ-017 if_pc  out  XLEN  PC of head instruction.
REQ-018 if_instr  out  ILEN  head instruction.
REQ-019 if_ready  in  1  decode accepts head (pop when if_valid&if_ready).

Function
REQ-020 FSM states SEQ_IDLE, SEQ_REQ, SEQ_WAIT, SEQ_DROP; exactly one request outstanding at a time.
REQ-021 SEQ_IDLE: all request/PC outputs 0; next state SEQ_REQ unconditionally.
REQ-022 SEQ_REQ: imem_req=1, imem_addr=pc_cur, only when fq_count+0 < FQ_DEPTH (credit for the one in-flight slot); otherwise imem_req=0, stay.
REQ-023 SEQ_REQ with imem_gnt: pc_write=1, pc_next=pc_cur+4 (mod 2^XLEN, wrap silently), latch req_pc=pc_cur, go SEQ_WAIT.
REQ-024 SEQ_WAIT: imem_req=0; on imem_rvalid push {req_pc, imem_rdata} into queue, go SEQ_REQ; response latency from gnt unbounded (>=1 cycle).
REQ-025 redirect (any state except SEQ_IDLE) has priority: pc_write=1, pc_next=redirect_pc, queue cleared same edge, no push, gnt ignored that cycle.
REQ-026 redirect in SEQ_WAIT without rvalid -> SEQ_DROP; redirect in SEQ_WAIT with rvalid -> SEQ_REQ (response discarded).
REQ-027 SEQ_DROP: discard next imem_rvalid, then SEQ_REQ; a further redirect in SEQ_DROP updates PC, stays SEQ_DROP.
REQ-028 pc_write=0 whenever neither gnt-advance nor redirect applies (PC holds).
REQ-029 if_valid = queue non-empty; if_pc/if_instr = head entry, stable while if_valid&!if_ready.
REQ-030 Simultaneous push and pop on a full queue: legal, count unchanged; push when full never occurs by REQ-022.
REQ-031 Simultaneous redirect and pop: flush wins; queue empty next cycle.

Reset
REQ-032 rst asserted: state SEQ_IDLE, queue empty, req_pc=0; pc_write=0, pc_next=0, imem_req=0, imem_addr=0, if_valid=0, if_pc=0, if_instr=0, asynchronously.
REQ-033 rst mid-transaction: outstanding response forgotten; a late imem_rvalid after reset in SEQ_IDLE/SEQ_REQ is ignored.

Structure
REQ-034 Shared package fetch_pkg holds XLEN, ILEN, INSTR_BYTES=4, and the FSM state enum.
REQ-035 Queue is sub-module fetch_fifo (synchronous push/pop/flush, count output, async rst); FSM and PC arithmetic stay in fetch_ctrl.

Verification
REQ-036 Reset release, pc_cur=0, gnt immediate, rvalid 1 cycle later, if_ready=1 -> pc_next 0x4,0x8,... and if_pc 0x0,0x4,... in order, one instruction per 2 cycles.
REQ-037 if_ready=0, FQ_DEPTH=2 -> exactly two pushes (PC 0x0,0x4), then imem_req=0 and pc_write=0 until a pop.
REQ-038 redirect with redirect_pc=0x100 in SEQ_WAIT, rvalid 3 cycles later -> response dropped, queue empty, next imem_addr=0x100.
REQ-039 redirect coincident with gnt at pc_cur=0x40 -> pc_next=0x200 (not 0x44), state SEQ_REQ, no request outstanding.
REQ-040 pc_cur=0xFFFF_FFFF_FFFF_FFFC with gnt -> pc_next=0x0.
REQ-041 rst pulsed during SEQ_WAIT, rvalid arrives after release -> all outputs 0 during rst, stale rvalid ignored, if_valid stays 0.
